// File: rtl/vga_pkg.sv
// Shared constants and types for the text-mode VGA pipeline.
package vga_pkg;

  localparam int TILE_W       = 8;
  localparam int TILE_H       = 8;
  localparam int GLYPH_ROM_AW = 14;

  localparam logic [7:0] BLACK  = 8'h00;
  localparam logic [7:0] DEF_BG = 8'h18;
  localparam logic [7:0] WHITE  = 8'hFF;

  localparam logic SYNC_IDLE_DEF = 1'b1;

  typedef struct packed {
    logic       pix_en;
    logic [7:0] bg;
    logic [2:0] col;
    logic       inv;
    logic       hs;
    logic       vs;
  } pix_s1_t;

  // Glyph rows are stored MSB-first: column 0 is bit 7.
  function automatic logic pick_bit(
    input logic [7:0] row,
    input logic [2:0] col
  );
    return row[3'd7 - col];
  endfunction

endpackage

// File: rtl/vga_blink_timer.sv
// Cursor blink timer: counts frame starts, toggles phase each half-period.
module vga_blink_timer
  import vga_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic        SYNC_IDLE    = SYNC_IDLE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic vsyncIn,
  output logic blinkPhase
);

  localparam logic [7:0] LAST = 8'(BLINK_FRAMES - 1);

  logic       vs_prev_q, vs_prev_d;
  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  logic       frame_start;

  always_comb begin
    frame_start = (vs_prev_q == SYNC_IDLE) && (vsyncIn != SYNC_IDLE);
    vs_prev_d   = vsyncIn;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    if (frame_start) begin
      if (cnt_q == LAST) begin
        cnt_d   = 8'd0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_q <= SYNC_IDLE;
      cnt_q     <= 8'd0;
      phase_q   <= 1'b0;
    end else begin
      vs_prev_q <= vs_prev_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign blinkPhase = phase_q;

endmodule

// File: rtl/vga_glyph_pixel.sv
// Glyph ROM driver and pixel serialiser: 2-cycle pipe to RGB332 + syncs.
module vga_glyph_pixel
  import vga_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic        SYNC_IDLE    = SYNC_IDLE_DEF,
  parameter int          ROM_AW       = GLYPH_ROM_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixEn,
  input  logic [ROM_AW-1:0] glyphAddr,
  input  logic [7:0]        bgColor,
  input  logic [7:0]        fgColor,
  input  logic [2:0]        colIdx,
  input  logic              cursorHit,
  input  logic              cursorEn,
  input  logic              hsyncIn,
  input  logic              vsyncIn,
  output logic [ROM_AW-1:0] romAddr,
  output logic              romEn,
  input  logic [7:0]        romData,
  output logic [7:0]        rgb,
  output logic              hsyncOut,
  output logic              vsyncOut,
  output logic              blinkPhase
);

  localparam pix_s1_t S1_RST = '{
    pix_en: 1'b0,
    bg:     BLACK,
    col:    3'd0,
    inv:    1'b0,
    hs:     SYNC_IDLE,
    vs:     SYNC_IDLE
  };

  pix_s1_t    s1_q, s1_d;
  logic [7:0] rgb_q, rgb_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blink_phase;
  logic       pix_on;

  vga_blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES),
    .SYNC_IDLE    (SYNC_IDLE)
  ) u_blink (
    .clk        (clk),
    .reset      (reset),
    .vsyncIn    (vsyncIn),
    .blinkPhase (blink_phase)
  );

  assign romAddr = glyphAddr;
  assign romEn   = pixEn & ~reset;

  always_comb begin
    s1_d.pix_en = pixEn;
    s1_d.bg     = bgColor;
    s1_d.col    = colIdx;
    s1_d.inv    = cursorHit & cursorEn & blink_phase;
    s1_d.hs     = hsyncIn;
    s1_d.vs     = vsyncIn;
  end

  // romData lines up with s1_q: the ROM has one cycle of read latency.
  always_comb begin
    pix_on = pick_bit(romData, s1_q.col) ^ s1_q.inv;
    rgb_d  = BLACK;
    if (s1_q.pix_en) begin
      rgb_d = pix_on ? fgColor : s1_q.bg;
    end
    hs_d = s1_q.hs;
    vs_d = s1_q.vs;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= S1_RST;
      rgb_q <= BLACK;
      hs_q  <= SYNC_IDLE;
      vs_q  <= SYNC_IDLE;
    end else begin
      s1_q  <= s1_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign rgb        = rgb_q;
  assign hsyncOut   = hs_q;
  assign vsyncOut   = vs_q;
  assign blinkPhase = blink_phase;

endmodule

// File: tb/tb_vga_glyph_pixel.sv
// Directed bench for vga_glyph_pixel: vector table plus corner sequences.
module tb_vga_glyph_pixel;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixEn;
  logic [13:0] glyphAddr;
  logic [7:0]  bgColor;
  logic [7:0]  fgColor;
  logic [2:0]  colIdx;
  logic        cursorHit;
  logic        cursorEn;
  logic        hsyncIn;
  logic        vsyncIn;
  logic [13:0] romAddr;
  logic        romEn;
  logic [7:0]  romData;
  logic [7:0]  rgb;
  logic        hsyncOut;
  logic        vsyncOut;
  logic        blinkPhase;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_glyph_pixel #(
    .BLINK_FRAMES (2),
    .SYNC_IDLE    (1'b1),
    .ROM_AW       (14)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixEn      (pixEn),
    .glyphAddr  (glyphAddr),
    .bgColor    (bgColor),
    .fgColor    (fgColor),
    .colIdx     (colIdx),
    .cursorHit  (cursorHit),
    .cursorEn   (cursorEn),
    .hsyncIn    (hsyncIn),
    .vsyncIn    (vsyncIn),
    .romAddr    (romAddr),
    .romEn      (romEn),
    .romData    (romData),
    .rgb        (rgb),
    .hsyncOut   (hsyncOut),
    .vsyncOut   (vsyncOut),
    .blinkPhase (blinkPhase)
  );

  typedef struct {
    logic        pix;
    logic [13:0] addr;
    logic [7:0]  bg;
    logic [2:0]  col;
    logic        hit;
    logic        hs;
    logic [7:0]  rom;
    logic [7:0]  exp_rgb;
    logic        exp_hs;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [13:0] act,
                     input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    pixEn     = 1'b0;
    glyphAddr = 14'h0;
    bgColor   = 8'h18;
    colIdx    = 3'd0;
    cursorHit = 1'b0;
    hsyncIn   = 1'b1;
    vsyncIn   = 1'b1;
  endtask

  task automatic cursor_pix(input string name, input logic [2:0] col,
                            input logic [7:0] rom, input logic [7:0] exp);
    pixEn     = 1'b1;
    glyphAddr = 14'h208;
    colIdx    = col;
    cursorHit = 1'b1;
    step();
    idle();
    romData = rom;
    step();
    chk(name, {6'd0, rgb}, {6'd0, exp});
  endtask

  initial begin
    logic [7:0] row_exp [8];
    logic       exp_h, exp_v;
    row_exp = '{8'h18, 8'h18, 8'h18, 8'hFF, 8'hFF, 8'h18, 8'h18, 8'h18};
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 14'h208, 8'h18, 3'(i), 1'b0, 1'b1, 8'h18,
                 row_exp[i], 1'b1};
    tbl[8]  = '{1'b0, 14'h010, 8'h18, 3'd3, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1};
    tbl[9]  = '{1'b1, 14'h208, 8'h18, 3'd3, 1'b1, 1'b1, 8'h18, 8'hFF, 1'b1};
    tbl[10] = '{1'b1, 14'h3C0, 8'h03, 3'd0, 1'b0, 1'b0, 8'h80, 8'hFF, 1'b0};
    tbl[11] = '{1'b1, 14'h3C1, 8'h03, 3'd1, 1'b0, 1'b0, 8'h80, 8'h03, 1'b0};
    tbl[12] = '{1'b1, 14'h1F7, 8'hE0, 3'd7, 1'b0, 1'b1, 8'h01, 8'hFF, 1'b1};
    tbl[13] = '{1'b1, 14'h1F7, 8'hE0, 3'd6, 1'b0, 1'b1, 8'h01, 8'hE0, 1'b1};

    // Reset with random inputs.
    reset    = 1'b1;
    fgColor  = 8'hFF;
    cursorEn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      pixEn     = 1'($urandom);
      glyphAddr = 14'($urandom);
      bgColor   = 8'($urandom);
      colIdx    = 3'($urandom);
      cursorHit = 1'($urandom);
      hsyncIn   = 1'($urandom);
      vsyncIn   = 1'($urandom);
      romData   = 8'($urandom);
      #1;
      chk("rst_romEn", {13'd0, romEn}, 14'd0);
      step();
      chk("rst_rgb", {6'd0, rgb}, 14'h00);
      chk("rst_hs", {13'd0, hsyncOut}, 14'd1);
      chk("rst_vs", {13'd0, vsyncOut}, 14'd1);
      chk("rst_blink", {13'd0, blinkPhase}, 14'd0);
    end
    reset = 1'b0;

    // Vector table: result of vector i appears two edges later.
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) begin
        chk($sformatf("vec%0d_rgb", i - 2), {6'd0, rgb},
            {6'd0, tbl[i-2].exp_rgb});
        chk($sformatf("vec%0d_hs", i - 2), {13'd0, hsyncOut},
            {13'd0, tbl[i-2].exp_hs});
      end
      if (i < NV) begin
        pixEn     = tbl[i].pix;
        glyphAddr = tbl[i].addr;
        bgColor   = tbl[i].bg;
        colIdx    = tbl[i].col;
        cursorHit = tbl[i].hit;
        hsyncIn   = tbl[i].hs;
        vsyncIn   = 1'b1;
      end else begin
        idle();
      end
      if (i >= 1 && i <= NV) romData = tbl[i-1].rom;
      #1;
      if (i < NV) begin
        chk($sformatf("vec%0d_romAddr", i), romAddr, tbl[i].addr);
        chk($sformatf("vec%0d_romEn", i), {13'd0, romEn},
            {13'd0, tbl[i].pix});
      end
      step();
    end

    // Sync alignment over a long hsync pulse and a vsync pulse.
    idle();
    for (int c = 0; c < 116; c++) begin
      if (c >= 2) begin
        exp_h = !((c - 2) >= 10 && (c - 2) <= 105);
        exp_v = !((c - 2) >= 20 && (c - 2) <= 60);
        chk($sformatf("sync_hs_c%0d", c), {13'd0, hsyncOut}, {13'd0, exp_h});
        chk($sformatf("sync_vs_c%0d", c), {13'd0, vsyncOut}, {13'd0, exp_v});
      end
      hsyncIn = !(c >= 10 && c <= 105);
      vsyncIn = !(c >= 20 && c <= 60);
      step();
    end
    chk("one_frame_blink", {13'd0, blinkPhase}, 14'd0);

    // Clear frame count, then two frame starts flip the phase.
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vsyncIn = 1'b0;
    step();
    vsyncIn = 1'b1;
    step();
    chk("blink_after_1", {13'd0, blinkPhase}, 14'd0);
    vsyncIn = 1'b0;
    step();
    chk("blink_after_2", {13'd0, blinkPhase}, 14'd1);
    vsyncIn = 1'b1;
    step();

    cursor_pix("cursor_col3", 3'd3, 8'h18, 8'h18);
    cursor_pix("cursor_col0", 3'd0, 8'h18, 8'hFF);
    cursorEn = 1'b0;
    cursor_pix("cursor_off_col3", 3'd3, 8'h18, 8'hFF);
    cursorEn = 1'b1;

    // Reset in the middle of a stream of lit pixels.
    pixEn     = 1'b1;
    cursorHit = 1'b0;
    romData   = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      colIdx = 3'(c);
      step();
    end
    chk("stream_rgb", {6'd0, rgb}, 14'h0FF);
    reset = 1'b1;
    step();
    chk("midrst_rgb", {6'd0, rgb}, 14'h00);
    chk("midrst_blink", {13'd0, blinkPhase}, 14'd0);
    chk("midrst_hs", {13'd0, hsyncOut}, 14'd1);
    reset = 1'b0;
    step();
    chk("post_rst_1", {6'd0, rgb}, 14'h00);
    step();
    chk("post_rst_2", {6'd0, rgb}, 14'h0FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_glyph_pixel.md
Name: vga_glyph_pixel

Overview:
Downstream neighbour of the VGA glyph-address stage in the text-mode pipeline. It takes the registered glyph-row address, pixel enable and background colour from that stage, and drives the synchronous glyph ROM. It then selects the current pixel bit from the returned row byte and emits the final RGB332 pixel with the HSYNC/VSYNC outputs aligned to it. It also owns the cursor blink timer and applies the fg/bg invert on the cursor cell.

Parameters:
BLINK_FRAMES, 30, frames per blink half-period (range 1..255).
SYNC_IDLE, 1, inactive level of hsync/vsync (1 = active-low syncs).
ROM_AW, 14, glyph ROM address width ({charcode, row}).

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
pixEn  in  1  pixel enable from the address stage
glyphAddr  in  ROM_AW  glyph row address from the address stage
bgColor  in  8  background colour (RGB332), aligned with glyphAddr
fgColor  in  8  foreground colour (RGB332), quasi-static control register
colIdx  in  3  pixel column within tile (hCount[2:0]), aligned with glyphAddr
cursorHit  in  1  current tile is the cursor cell, aligned with glyphAddr
cursorEn  in  1  cursor display enable, quasi-static
hsyncIn  in  1  hsync, aligned with glyphAddr
vsyncIn  in  1  vsync, aligned with glyphAddr
romAddr  out  ROM_AW  glyph ROM address
romEn  out  1  glyph ROM read enable
romData  in  8  glyph ROM row byte; bit 7 = leftmost pixel; valid 1 cycle after romAddr
rgb  out  8  final pixel, RGB332
hsyncOut  out  1  hsync aligned with rgb
vsyncOut  out  1  vsync aligned with rgb
blinkPhase  out  1  current blink phase, for status readback

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state is updated on posedge clk only.
- Reset values: rgb=8'h00, hsyncOut=vsyncOut=SYNC_IDLE, blinkPhase=0, frame counter=0. All pipeline valid/enable flags are cleared.
- ROM interface:
  - romAddr = glyphAddr, combinational passthrough.
  - romEn = pixEn & ~reset.
- Stage 1 (edge t+1) registers: pixEn, bgColor, colIdx, the cursor-invert flag (cursorHit & cursorEn & blinkPhase), hsyncIn and vsyncIn. The ROM delivers romData in this same cycle.
- Stage 2 (edge t+2) computes:
  - bit = romData[7 - colIdx_s1]
  - on = bit XOR invert_s1
  - rgb <= pixEn_s1 ? (on ? fgColor : bgColor_s1) : 8'h00
- Syncs are delayed 2 cycles so they stay aligned with rgb.
- Latency: exactly 2 clk from input to rgb/hsyncOut/vsyncOut. Throughput is 1 pixel/clk, with no stalls.
- Blink timer:
  - Frame start = vsyncIn transitioning from SYNC_IDLE to active, detected with a registered previous value.
  - On each frame start the counter increments. When it reaches BLINK_FRAMES-1 the counter wraps to 0 and blinkPhase toggles.
  - With BLINK_FRAMES=1, blinkPhase toggles on every frame start.
  - A frame start during the reset cycle is ignored.
- fgColor and cursorEn are sampled at stage 2 and stage 1 respectively. Changing either mid-line takes effect at the next pixel. No glitch-free requirement.
- pixEn=0: rgb=0 regardless of romData or cursor state. Syncs still propagate.
- Reset mid-line: the next edge forces outputs to reset values. The first valid rgb appears 2 cycles after reset deasserts; the cycles before that are black with idle syncs.

Decomposition:
- Shared package vga_pkg holds:
  - TILE_W=8, TILE_H=8, GLYPH_ROM_AW=14
  - RGB332 constants: BLACK=8'h00, DEF_BG=8'h18, WHITE=8'hFF
  - SYNC_IDLE default
- One sub-module, vga_blink_timer: inputs clk, reset, vsyncIn; output blinkPhase. It contains the frame-start edge detect and the counter.

Test Plan:
- Reset: hold reset 3 cycles with random inputs -> rgb=00, hsyncOut=vsyncOut=1, blinkPhase=0, romEn=0.
- Glyph row: pixEn=1, glyphAddr=14'h208, romData=8'b00011000, fg=FF, bg=18, colIdx 0..7 on consecutive cycles -> rgb from t+2 = 18,18,18,FF,FF,18,18,18. romAddr=208 combinationally.
- Blank: pixEn=0, romData=FF, colIdx=3 -> rgb=00 at t+2, and romEn=0.
- Sync alignment: hsyncIn low for cycles 10..105 -> hsyncOut low for cycles 12..107. vsyncIn likewise offset by 2.
- Blink (BLINK_FRAMES=2): two vsync falling edges -> blinkPhase 0->1. Then cursorHit=1, cursorEn=1, romData=8'b00011000, colIdx=3 -> rgb=18; colIdx=0 -> rgb=FF.
- Reset mid-line: pixEn=1 streaming FF pixels, reset asserted 1 cycle -> rgb=00 on the following edge, blinkPhase=0. Valid FF resumes exactly 2 cycles after deassert.
